// File: rtl/addsub_arbiter_if.sv
// rtl/addsub_arbiter_if.sv - request/response bundle between requesters, consumer and addsub_arbiter
interface addsub_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_ov;
    logic             rsp_id;

    // Requesters and the result consumer
    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_sum, rsp_ov, rsp_id,
        output rsp_ready
    );

    // The arbiter itself
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp_valid, rsp_sum, rsp_ov, rsp_id,
        input  rsp_ready
    );
endinterface

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin shared add/sub unit; optional clamp via ADDSUB_SAT_EN
module addsub_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    addsub_arbiter_if.slave   bus,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             op_q, op_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_ov_q, rsp_ov_d;
    logic             rsp_id_q, rsp_id_d;

    logic             grant_any;
    logic             grant_id;
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             c_msb;
    logic             ov;
    logic [WIDTH-1:0] res;

    // Pick a requester: the only valid one, or the one not served last on contention
    always_comb begin
        grant_any = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = bus.req1_valid;
        end
    end

    // Add/sub on latched operands; subtraction is A + ~B + 1
    always_comb begin
        bb             = b_q ^ {WIDTH{op_q}};
        {c_out, sum}   = {1'b0, a_q} + {1'b0, bb} + {{WIDTH{1'b0}}, op_q};
        c_msb          = sum[WIDTH-1] ^ a_q[WIDTH-1] ^ bb[WIDTH-1];
        ov             = c_msb ^ c_out;
        res            = sum;
`ifdef ADDSUB_SAT_EN
        if (ov) begin
            res = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 1'b0;
            id_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_sum_q    <= '0;
            rsp_ov_q     <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_ov_q     <= rsp_ov_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    // Next state: latch on grant, register result in CALC, release on response handshake
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_ov_d     = rsp_ov_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    state_d      = CALC;
                    last_grant_d = grant_id;
                    id_d         = grant_id;
                    a_d          = grant_id ? bus.req1_a  : bus.req0_a;
                    b_d          = grant_id ? bus.req1_b  : bus.req0_b;
                    op_d         = grant_id ? bus.req1_op : bus.req0_op;
                end
            end
            CALC: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_sum_d   = res;
                rsp_ov_d    = ov;
                rsp_id_d    = id_q;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ready only for the granted requester while idle, response from registers
    always_comb begin
        bus.req0_ready = (state_q == IDLE) && grant_any && !grant_id;
        bus.req1_ready = (state_q == IDLE) && grant_any && grant_id;
        bus.rsp_valid  = rsp_valid_q;
        bus.rsp_sum    = rsp_sum_q;
        bus.rsp_ov     = rsp_ov_q;
        bus.rsp_id     = rsp_id_q;
        busy           = (state_q != IDLE);
    end
endmodule
